// File: rtl/tpg_mode_sched_pkg.sv
// ----------------------------------------------------------------------------
// tpg_mode_sched_pkg
// Shared video definitions used by tpg, vga_timing and tpg_mode_sched:
//   - tpg_mode_t     : test-pattern mode encoding (bars/grid/checker/markers)
//   - V_ACTIVE       : first vertical blanking line index
//   - sched_state_t  : mode-scheduler FSM states
//   - mode_step()    : next mode in the cycling order, wrapping 3 -> 0
// ----------------------------------------------------------------------------
package tpg_mode_sched_pkg;

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_GRID  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_CHAR  = 2'd3
   } tpg_mode_t;

   localparam int unsigned V_ACTIVE = 480;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } sched_state_t;

   // Natural 2-bit overflow gives the 3 -> 0 wrap.
   function automatic logic [1:0] mode_step(input logic [1:0] m);
      return m + 2'd1;
   endfunction

endpackage

// File: rtl/tpg_mode_sched_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a level debouncer for a raw push-button.
// The stable level only follows the synchronized level after it has differed
// for DEBOUNCE_CYCLES consecutive cycles; btn_rise pulses for one cycle when
// the stable level goes 0 -> 1.
// Ports:
//   clk_pix   in  : pixel clock
//   reset     in  : synchronous active-high reset
//   btn_raw   in  : asynchronous button, high = pressed
//   btn_rise  out : one-cycle pulse on an accepted press
// ----------------------------------------------------------------------------
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk_pix,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_rise
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         stable   <= 1'b0;
         cnt      <= '0;
         btn_rise <= 1'b0;
      end else begin
         sync_1   <= btn_raw;
         sync_2   <= sync_1;
         btn_rise <= 1'b0;
         if (sync_2 != stable) begin
            if (cnt == CNT_LAST) begin
               stable   <= sync_2;
               cnt      <= '0;
               // Only the press direction generates a request.
               btn_rise <= sync_2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/tpg_mode_sched.sv
// ----------------------------------------------------------------------------
// tpg_mode_sched
// Selects the test-pattern mode. Requests (button press, auto-cycle step,
// direct cfg_load) are held in a single pending slot and applied only at the
// frame boundary (hcount==0, vcount==V_ACTIVE), so every mode change lands in
// vertical blanking.
// Ports:
//   clk_pix       in  : pixel clock, only clock
//   reset         in  : synchronous active-high reset
//   hcount[9:0]   in  : horizontal position
//   vcount[9:0]   in  : vertical position
//   btn_next      in  : raw push-button, high = pressed
//   auto_en       in  : level, enables auto-cycling every AUTO_FRAMES frames
//   cfg_load      in  : one-cycle pulse, load cfg_mode directly
//   cfg_mode[1:0] in  : target mode for cfg_load
//   mode[1:0]     out : registered current mode
//   mode_changed  out : one-cycle pulse with each mode update
//   frame_tick    out : one-cycle pulse the cycle after each frame boundary
// ----------------------------------------------------------------------------
module tpg_mode_sched #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned AUTO_FRAMES     = 120,
   parameter int unsigned V_ACTIVE        = tpg_mode_sched_pkg::V_ACTIVE
) (
   input  logic       clk_pix,
   input  logic       reset,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       btn_next,
   input  logic       auto_en,
   input  logic       cfg_load,
   input  logic [1:0] cfg_mode,
   output logic [1:0] mode,
   output logic       mode_changed,
   output logic       frame_tick
);

   import tpg_mode_sched_pkg::*;

   localparam logic [9:0] VACT_LINE = 10'(V_ACTIVE);
   localparam int unsigned AUTO_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);

   sched_state_t      state;
   logic [1:0]        target;
   logic [AUTO_W-1:0] auto_cnt;

   logic       btn_rise;
   logic       boundary;
   logic       auto_wrap;
   logic       take_inc;
   logic       new_req;
   logic [1:0] next_target;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk_pix (clk_pix),
      .reset   (reset),
      .btn_raw (btn_next),
      .btn_rise(btn_rise)
   );

   assign boundary = (hcount == '0) && (vcount == VACT_LINE);

   // Request arbitration. cfg_load always wins and overwrites a pending
   // target; an INC (button or auto wrap) is taken only from RUN. The
   // resulting target is used both to fill the slot and, in the boundary
   // cycle itself, to update mode directly.
   always_comb begin
      auto_wrap   = 1'b0;
      take_inc    = 1'b0;
      new_req     = 1'b0;
      next_target = target;

      auto_wrap = auto_en && boundary && (auto_cnt == AUTO_LAST);
      take_inc  = (btn_rise || auto_wrap) && (state == ST_RUN) && !cfg_load;
      new_req   = cfg_load || take_inc;

      if (cfg_load)
         next_target = cfg_mode;
      else if (take_inc)
         next_target = mode_step(mode);
   end

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         state        <= ST_RUN;
         target       <= MODE_BARS;
         mode         <= MODE_BARS;
         mode_changed <= 1'b0;
         frame_tick   <= 1'b0;
         auto_cnt     <= '0;
      end else begin
         frame_tick   <= boundary;
         mode_changed <= 1'b0;

         // Any explicit user action restarts the auto-cycle interval.
         if (!auto_en || cfg_load || (btn_rise && state == ST_RUN))
            auto_cnt <= '0;
         else if (boundary)
            auto_cnt <= auto_wrap ? '0 : auto_cnt + 1'b1;

         case (state)
            ST_RUN: begin
               if (new_req) begin
                  if (boundary) begin
                     mode         <= next_target;
                     mode_changed <= 1'b1;
                  end else begin
                     target <= next_target;
                     state  <= ST_PEND;
                  end
               end
            end
            ST_PEND: begin
               if (boundary) begin
                  mode         <= next_target;
                  mode_changed <= 1'b1;
                  state        <= ST_RUN;
               end else begin
                  target <= next_target;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_tpg_mode_sched.sv
module tb_tpg_mode_sched;

   localparam int unsigned H_TOTAL = 8;
   localparam int unsigned V_TOTAL = 6;
   localparam int unsigned VA      = 4;

   logic       clk_pix = 1'b0;
   logic       reset;
   logic [9:0] hcount = '0;
   logic [9:0] vcount = '0;
   logic       btn_next;
   logic       auto_en;
   logic       cfg_load;
   logic [1:0] cfg_mode;
   logic [1:0] mode;
   logic       mode_changed;
   logic       frame_tick;

   int vectors    = 0;
   int miscompares = 0;
   int stray      = 0;
   logic [1:0] last_mode = '0;

   typedef struct {
      logic       chg;
      logic [1:0] m;
      string      tag;
   } exp_t;
   exp_t sb[$];

   tpg_mode_sched #(
      .DEBOUNCE_CYCLES(4),
      .AUTO_FRAMES    (2),
      .V_ACTIVE       (VA)
   ) dut (
      .clk_pix     (clk_pix),
      .reset       (reset),
      .hcount      (hcount),
      .vcount      (vcount),
      .btn_next    (btn_next),
      .auto_en     (auto_en),
      .cfg_load    (cfg_load),
      .cfg_mode    (cfg_mode),
      .mode        (mode),
      .mode_changed(mode_changed),
      .frame_tick  (frame_tick)
   );

   always #5 clk_pix = ~clk_pix;

   // Reduced-frame timing model: 8 pixels x 6 lines, boundary at line 4.
   always @(posedge clk_pix) begin
      if (hcount == 10'(H_TOTAL - 1)) begin
         hcount <= '0;
         vcount <= (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
      end else begin
         hcount <= hcount + 1'b1;
      end
   end

   // Mode may only move (and mode_changed only pulse) alongside frame_tick.
   always @(negedge clk_pix) begin
      if (!reset && !frame_tick && (mode_changed || mode !== last_mode))
         stray++;
      last_mode <= mode;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_pix);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic chg, input logic [1:0] m);
      exp_t e;
      e.chg = chg;
      e.m   = m;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic tick_check();
      exp_t e;
      logic found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_pix);
         if (frame_tick) begin
            found = 1'b1;
            break;
         end
      end
      e = sb.pop_front();
      check({e.tag, "_tick"}, {7'd0, found}, 8'd1);
      check({e.tag, "_mode"}, {6'd0, mode}, {6'd0, e.m});
      check({e.tag, "_chg"}, {7'd0, mode_changed}, {7'd0, e.chg});
   endtask

   task automatic press(input int n);
      btn_next = 1'b1;
      cyc(n);
      btn_next = 1'b0;
      cyc(8);
   endtask

   task automatic load(input logic [1:0] m);
      cfg_load = 1'b1;
      cfg_mode = m;
      cyc(1);
      cfg_load = 1'b0;
   endtask

   initial begin
      logic found;
      reset    = 1'b1;
      btn_next = 1'b0;
      auto_en  = 1'b0;
      cfg_load = 1'b0;
      cfg_mode = 2'd0;
      cyc(3);
      check("reset_mode", {6'd0, mode}, 8'd0);
      check("reset_chg", {7'd0, mode_changed}, 8'd0);
      check("reset_tick", {7'd0, frame_tick}, 8'd0);
      reset = 1'b0;

      push_exp("idle", 1'b0, 2'd0);
      tick_check();

      // Glitch shorter than the debounce window is ignored.
      btn_next = 1'b1;
      cyc(3);
      btn_next = 1'b0;
      cyc(2);
      push_exp("short_press", 1'b0, 2'd0);
      tick_check();

      press(10);
      push_exp("long_press", 1'b1, 2'd1);
      tick_check();
      push_exp("long_once", 1'b0, 2'd1);
      tick_check();

      // Press followed by cfg_load: cfg_load overwrites pending INC.
      btn_next = 1'b1;
      cyc(10);
      btn_next = 1'b0;
      cyc(2);
      load(2'd3);
      push_exp("btn_then_cfg", 1'b1, 2'd3);
      tick_check();

      // Two presses in one frame: single step, 3 wraps to 0.
      press(7);
      press(7);
      push_exp("double_press", 1'b1, 2'd0);
      tick_check();

      load(2'd2);
      push_exp("cfg_load2", 1'b1, 2'd2);
      tick_check();

      auto_en = 1'b1;
      push_exp("auto1", 1'b0, 2'd2);
      tick_check();
      push_exp("auto2", 1'b1, 2'd3);
      tick_check();
      push_exp("auto3", 1'b0, 2'd3);
      tick_check();
      push_exp("auto4", 1'b1, 2'd0);
      tick_check();
      auto_en = 1'b0;
      push_exp("auto_off1", 1'b0, 2'd0);
      tick_check();
      push_exp("auto_off2", 1'b0, 2'd0);
      tick_check();

      load(2'd0);
      push_exp("same_mode", 1'b1, 2'd0);
      tick_check();

      // cfg_load driven exactly in the boundary cycle.
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         if (hcount == '0 && vcount == 10'(VA)) begin
            found = 1'b1;
            break;
         end
      end
      check("find_boundary", {7'd0, found}, 8'd1);
      load(2'd1);
      check("edge_next_cycle", {6'd0, mode}, 8'd1);
      push_exp("edge_load", 1'b1, 2'd1);
      tick_check();

      // Reset while a request is pending discards it.
      load(2'd3);
      cyc(2);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      check("pend_reset_mode", {6'd0, mode}, 8'd0);
      push_exp("after_pend_reset", 1'b0, 2'd0);
      tick_check();

      check("stray_changes", 8'(stray), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tpg_mode_sched.md
TPG_MODE_SCHED -- requirements
Module: tpg_mode_sched

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive clk_pix cycles a button level must hold to be accepted (10 ms at 25 MHz).
REQ-002 Parameter AUTO_FRAMES, default 120: frames per auto-cycle step.
REQ-003 Parameter V_ACTIVE, default 480: first blanking line index.
REQ-004 clk_pix  input  1: pixel clock, ~25 MHz, the only clock.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 hcount  input  10: horizontal position from vga_timing.
REQ-007 vcount  input  10: vertical position from vga_timing.
REQ-008 btn_next  input  1: raw asynchronous push-button, high = pressed.
REQ-009 auto_en  input  1: level; enables auto-cycling.
REQ-010 cfg_load  input  1: single-cycle pulse; requests a direct mode load.
REQ-011 cfg_mode  input  2: target mode, sampled only when cfg_load=1.
REQ-012 mode  output  2: registered TPG mode (0 = bars, 1 = grid, 2 = checker, 3 = char markers).
REQ-013 mode_changed  output  1: one-cycle pulse, coincident with a mode update.
REQ-014 frame_tick  output  1: one-cycle pulse at each frame boundary.

Function
REQ-015 Frame boundary: the cycle where hcount==0 and vcount==V_ACTIVE.
- frame_tick shall be registered and assert in the cycle after the boundary.
REQ-016 btn_next shall pass through a 2-FF synchronizer.
- A debounce counter shall increment while the synchronized level differs from the stable level, and clear otherwise.
- When the counter reaches DEBOUNCE_CYCLES-1, the stable level shall take the synchronized level and the counter shall clear.
REQ-017 A rising edge of the stable button level shall raise an INC request; a falling edge shall raise nothing.
REQ-018 Request arbitration: a single pending slot with a target mode.
- cfg_load shall have the highest priority and set target = cfg_mode.
- An INC request shall set target = mode+1 mod 4 only when no request is pending.
REQ-019 A later cfg_load shall overwrite any pending target, including a pending INC. Further INC requests while a request is pending shall be dropped (no double-step).
REQ-020 FSM states: RUN (no pending request) and PEND (request held).
- RUN to PEND on any accepted request.
- PEND to RUN at the frame boundary, when mode takes the target.
REQ-021 mode and mode_changed shall update on the clock edge ending the boundary cycle.
- mode shall never change at any other time, so every change falls in vertical blanking.
REQ-022 A request that arrives in the boundary cycle itself shall be applied at that boundary.
REQ-023 mode_changed shall pulse even when the target equals the current mode.
REQ-024 Auto frame counter:
- While auto_en=1, the counter shall increment at each boundary.
- At the boundary where it equals AUTO_FRAMES-1, it shall wrap to 0 and issue an INC request that is applied at that same boundary.
REQ-025 auto_en=0 shall hold the auto counter at 0. An accepted button INC or cfg_load shall also clear it.
REQ-026 Simultaneous auto and button INC shall produce a single increment. cfg_load together with an INC shall result in cfg_mode.
REQ-027 The increment shall wrap from 3 to 0.

Reset
REQ-028 When reset=1 at a clk_pix edge, the block shall enter this state: mode=0, mode_changed=0, frame_tick=0, FSM=RUN, pending cleared, debounce counter=0, auto counter=0, synchronizer flops=0, stable button level=0.
REQ-029 Reset asserted mid-debounce or while in PEND shall discard the press or pending request.

Structure
REQ-030 The shared video package shall hold the mode encoding constants (MODE_BARS, MODE_GRID, MODE_CHECK, MODE_CHAR) and V_ACTIVE, shared with tpg and vga_timing.
REQ-031 The synchronizer and debouncer shall form one sub-module, btn_debounce (clk_pix, reset, btn_raw, btn_rise).

Verification
REQ-032 Use DEBOUNCE_CYCLES=4 and AUTO_FRAMES=2 with a reduced-frame timing model for all scenarios.
REQ-033 Scenarios:
- Reset: hold reset 3 cycles -> mode=0, mode_changed=0, frame_tick=0.
- Debounce: btn high for 3 cycles then low -> no mode change at the next boundary. btn high for 10 cycles -> mode 0 to 1 at the first boundary after acceptance, with a single mode_changed pulse.
- Arbitration: button press, then cfg_load with cfg_mode=3 before the boundary -> mode=3 at the boundary. Two presses before one boundary -> single step.
- Auto-cycle: auto_en=1 from mode=2 -> mode=3 after 2 boundaries, then 0 after 2 more. auto_en=0 -> mode stable.
- Boundary edge case: cfg_load with cfg_mode=1 in the boundary cycle -> mode=1 in the next cycle. Reset while in PEND -> mode=0 and no change at the following boundary.
